// File: rtl/coeff_bank_loader.sv
// Double-buffered KSIZE x KSIZE coefficient store for the 2D FIR core.
// Host fills a shadow RAM, commits, and the next vsync rising edge swaps it in atomically.
module coeff_bank_loader #(
    parameter int KSIZE   = 5,
    parameter int COEFF_W = 16,
    parameter int ADDR_W  = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             vs_i,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [COEFF_W-1:0]               wr_data,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic                             commit,
    output logic [KSIZE*KSIZE*COEFF_W-1:0]   coeff_o,
    output logic                             pending_o,
    output logic                             busy_o,
    output logic                             swap_done,
    output logic                             err_addr
);
    localparam int N      = KSIZE * KSIZE;
    localparam int RAM_AW = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W  = $clog2(N + 1);
    localparam logic [CNT_W-1:0]  LAST   = CNT_W'(N);
    localparam logic [ADDR_W-1:0] N_ADDR = ADDR_W'(N);

    typedef enum logic [1:0] {IDLE, ARMED, LOAD, APPLY} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    logic                 vs_dly_q, vs_dly_d;
    logic [N*COEFF_W-1:0] stg_q, stg_d;
    logic [N*COEFF_W-1:0] coeff_q, coeff_d;
    logic                 swap_q, swap_d;
    logic                 err_q, err_d;
    logic [COEFF_W-1:0]   rd_q;
    logic [COEFF_W-1:0]   shadow_mem [N];

    logic vs_edge, wr_fire, wr_in_range, rd_en;

    assign vs_edge     = vs_i & ~vs_dly_q;
    assign wr_ready    = (state_q == IDLE) || (state_q == ARMED);
    assign busy_o      = (state_q == LOAD) || (state_q == APPLY);
    assign pending_o   = (state_q == ARMED) || pend_q;
    assign wr_fire     = wr_valid & wr_ready;
    assign wr_in_range = wr_addr < N_ADDR;
    assign rd_en       = (state_q == LOAD) && (cnt_q != LAST);
    assign coeff_o     = coeff_q;
    assign swap_done   = swap_q;
    assign err_addr    = err_q;

    // Shadow RAM is deliberately unreset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_fire && wr_in_range)
            shadow_mem[wr_addr[RAM_AW-1:0]] <= wr_data;
        if (rd_en)
            rd_q <= shadow_mem[cnt_q[RAM_AW-1:0]];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        stg_d    = stg_q;
        coeff_d  = coeff_q;
        swap_d   = 1'b0;
        vs_dly_d = vs_i;
        err_d    = err_q | (wr_fire & ~wr_in_range);
        unique case (state_q)
            IDLE: begin
                if (commit)
                    state_d = ARMED;
            end
            ARMED: begin
                if (vs_edge) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (commit)
                    pend_d = 1'b1;
                // Read data lags the address by one cycle.
                if (cnt_q != '0)
                    stg_d[(int'(cnt_q) - 1)*COEFF_W +: COEFF_W] = rd_q;
                if (cnt_q == LAST)
                    state_d = APPLY;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            APPLY: begin
                coeff_d = stg_q;
                swap_d  = 1'b1;
                pend_d  = 1'b0;
                state_d = (pend_q || commit) ? ARMED : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            vs_dly_q <= 1'b1;
            stg_q    <= '0;
            coeff_q  <= '0;
            swap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            vs_dly_q <= vs_dly_d;
            stg_q    <= stg_d;
            coeff_q  <= coeff_d;
            swap_q   <= swap_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_coeff_bank_loader.sv
// Self-checking bench for coeff_bank_loader against a bank-level model.
// Randomized coefficients; model tracks shadow, active bank, pending and error flag.
module tb_coeff_bank_loader;
    localparam int KSIZE   = 5;
    localparam int COEFF_W = 16;
    localparam int ADDR_W  = 8;
    localparam int N       = KSIZE * KSIZE;
    localparam int LAT     = N + 2;

    logic clk = 1'b0;
    logic rst, vs_i, wr_valid, wr_ready, commit;
    logic pending_o, busy_o, swap_done, err_addr;
    logic [ADDR_W-1:0]    wr_addr;
    logic [COEFF_W-1:0]   wr_data;
    logic [N*COEFF_W-1:0] coeff_o;

    int n_chk  = 0;
    int n_fail = 0;

    logic [COEFF_W-1:0] sh_m  [N];
    logic [COEFF_W-1:0] act_m [N];
    bit armed_m = 0;
    bit err_m   = 0;

    coeff_bank_loader #(.KSIZE(KSIZE), .COEFF_W(COEFF_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .vs_i(vs_i),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .commit(commit), .coeff_o(coeff_o),
        .pending_o(pending_o), .busy_o(busy_o), .swap_done(swap_done),
        .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*COEFF_W-1:0] flat_act();
        logic [N*COEFF_W-1:0] v;
        for (int i = 0; i < N; i++) v[i*COEFF_W +: COEFF_W] = act_m[i];
        return v;
    endfunction

    function automatic logic [N*COEFF_W-1:0] flat_sh();
        logic [N*COEFF_W-1:0] v;
        for (int i = 0; i < N; i++) v[i*COEFF_W +: COEFF_W] = sh_m[i];
        return v;
    endfunction

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [COEFF_W-1:0] d,
                      input bit with_commit);
        int t = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        while (wr_ready !== 1'b1 && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) begin
            n_chk++;
            n_fail++;
            $display("FAIL wr_timeout: addr %0d never accepted", a);
        end else begin
            commit = with_commit;
            if (int'(a) < N) sh_m[a] = d;
            else err_m = 1'b1;
            if (with_commit) armed_m = 1'b1;
            tick();
        end
        wr_valid = 1'b0;
        commit   = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        armed_m = 1'b1;
    endtask

    task automatic vs_swap(input bit hold_wr, input bit commit_mid, input string tag);
        logic [N*COEFF_W-1:0] old_v, new_v;
        bit exp_swap;
        int busy_n, swaps, swap_at, early, rdy_bad, hs_bad;
        exp_swap = armed_m;
        old_v    = flat_act();
        new_v    = exp_swap ? flat_sh() : old_v;
        vs_i = 1'b0;
        tick();
        vs_i = 1'b1;
        tick();
        n_chk++;
        if (pending_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pend_fall: pending_o=%b want 0", tag, pending_o);
        end
        busy_n  = int'(busy_o);
        swaps   = int'(swap_done);
        swap_at = -1;
        early   = 0;
        rdy_bad = (wr_ready !== !busy_o) ? 1 : 0;
        hs_bad  = 0;
        if (hold_wr) begin
            wr_valid = 1'b1;
            wr_addr  = '0;
            wr_data  = 16'h1234;
        end
        for (int k = 1; k <= LAT + 4; k++) begin
            commit = commit_mid && (k == 5);
            if (wr_valid && wr_ready) hs_bad++;
            tick();
            commit = 1'b0;
            if (busy_o) busy_n++;
            if (wr_ready !== !busy_o) rdy_bad++;
            if (swap_done) begin
                swaps++;
                if (swap_at < 0) swap_at = k;
                wr_valid = 1'b0;
            end
            if (swap_at < 0 && coeff_o !== old_v) early++;
        end
        wr_valid = 1'b0;
        if (exp_swap) begin
            for (int i = 0; i < N; i++) act_m[i] = sh_m[i];
            armed_m = commit_mid;
        end
        n_chk++;
        if (swaps !== (exp_swap ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s_swap_count: got %0d want %0d", tag, swaps, exp_swap);
        end
        if (exp_swap) begin
            n_chk++;
            if (swap_at !== LAT) begin
                n_fail++;
                $display("FAIL %s_latency: got %0d want %0d", tag, swap_at, LAT);
            end
        end
        n_chk++;
        if (busy_n !== (exp_swap ? LAT : 0)) begin
            n_fail++;
            $display("FAIL %s_busy_cycles: got %0d want %0d", tag, busy_n,
                     exp_swap ? LAT : 0);
        end
        n_chk++;
        if (coeff_o !== new_v) begin
            n_fail++;
            $display("FAIL %s_coeff: got %h want %h", tag, coeff_o, new_v);
        end
        n_chk++;
        if (early !== 0) begin
            n_fail++;
            $display("FAIL %s_early_change: coeff_o changed %0d cycles before swap", tag, early);
        end
        n_chk++;
        if (rdy_bad !== 0 || hs_bad !== 0) begin
            n_fail++;
            $display("FAIL %s_wr_ready: ready mismatches %0d, handshakes while busy %0d want 0 0",
                     tag, rdy_bad, hs_bad);
        end
        n_chk++;
        if (pending_o !== armed_m) begin
            n_fail++;
            $display("FAIL %s_pending_after: got %b want %b", tag, pending_o, armed_m);
        end
    endtask

    task automatic test_reset();
        bit saw = 0;
        rst = 1'b1; vs_i = 1'b1; wr_valid = 1'b0; commit = 1'b0;
        wr_addr = '0; wr_data = '0;
        for (int i = 0; i < N; i++) act_m[i] = '0;
        repeat (3) tick();
        n_chk++;
        if (coeff_o !== '0 || busy_o !== 1'b0 || pending_o !== 1'b0 ||
            swap_done !== 1'b0 || err_addr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: coeff=%h busy=%b pend=%b swap=%b err=%b want all 0",
                     coeff_o, busy_o, pending_o, swap_done, err_addr);
        end
        rst = 1'b0;
        repeat (10) begin
            tick();
            if (swap_done || busy_o) saw = 1'b1;
        end
        n_chk++;
        if (saw !== 1'b0 || coeff_o !== '0) begin
            n_fail++;
            $display("FAIL reset_vs_high: activity=%b coeff=%h want 0 0", saw, coeff_o);
        end
        n_chk++;
        if (wr_ready !== 1'b1 || pending_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: wr_ready=%b pending=%b want 1 0", wr_ready, pending_o);
        end
    endtask

    task automatic test_first_swap();
        logic [COEFF_W-1:0] e0, e24;
        e0  = 16'hFFEC;
        e24 = 16'd52;
        for (int i = 0; i < N; i++)
            wr(ADDR_W'(i), COEFF_W'(i * 3 - 20), i == N - 1);
        n_chk++;
        if (pending_o !== 1'b1) begin
            n_fail++;
            $display("FAIL commit_pending: got %b want 1", pending_o);
        end
        vs_swap(1'b0, 1'b0, "swap1");
        n_chk++;
        if (coeff_o[0 +: COEFF_W] !== e0 || coeff_o[24*COEFF_W +: COEFF_W] !== e24) begin
            n_fail++;
            $display("FAIL swap1_entries: e0=%h e24=%h want %h %h",
                     coeff_o[0 +: COEFF_W], coeff_o[24*COEFF_W +: COEFF_W], e0, e24);
        end
    endtask

    task automatic test_no_commit();
        vs_swap(1'b0, 1'b0, "novs1");
        vs_swap(1'b0, 1'b0, "novs2");
        n_chk++;
        if (coeff_o[12*COEFF_W +: COEFF_W] !== 16'd16) begin
            n_fail++;
            $display("FAIL novs_entry12: got %0d want 16", coeff_o[12*COEFF_W +: COEFF_W]);
        end
    endtask

    task automatic test_commit_vs_same();
        vs_i = 1'b0;
        tick();
        commit = 1'b1;
        vs_i   = 1'b1;
        tick();
        commit = 1'b0;
        armed_m = 1'b1;
        tick();
        n_chk++;
        if (busy_o !== 1'b0 || pending_o !== 1'b1) begin
            n_fail++;
            $display("FAIL commit_vs_same: busy=%b pending=%b want 0 1", busy_o, pending_o);
        end
        wr(ADDR_W'($urandom_range(0, N - 1)), COEFF_W'($urandom_range(0, 16'h7FFE)), 1'b0);
        vs_swap(1'b0, 1'b0, "armed_wr");
    endtask

    task automatic test_bad_addr();
        bit hit = 0;
        wr(ADDR_W'(30), 16'h7FFF, 1'b0);
        n_chk++;
        if (err_addr !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: got %b want 1", err_addr);
        end
        repeat (8)
            wr(ADDR_W'($urandom_range(0, N - 1)), COEFF_W'($urandom_range(0, 16'h7FFE)), 1'b0);
        do_commit();
        vs_swap(1'b0, 1'b0, "bad");
        for (int i = 0; i < N; i++)
            if (coeff_o[i*COEFF_W +: COEFF_W] === 16'h7FFF) hit = 1'b1;
        n_chk++;
        if (hit !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_discarded: 0x7FFF found on coeff_o, want absent");
        end
        n_chk++;
        if (err_addr !== err_m) begin
            n_fail++;
            $display("FAIL err_sticky: got %b want %b", err_addr, err_m);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < N; i++)
            wr(ADDR_W'(i), COEFF_W'($urandom), 1'b0);
        do_commit();
        vs_swap(1'b1, 1'b1, "b2b1");
        repeat (3)
            wr(ADDR_W'($urandom_range(0, N - 1)), COEFF_W'($urandom), 1'b0);
        vs_swap(1'b0, 1'b0, "b2b2");
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < N; i++)
            wr(ADDR_W'(i), COEFF_W'($urandom), 1'b0);
        do_commit();
        vs_i = 1'b0;
        tick();
        vs_i = 1'b1;
        tick();
        repeat (10) tick();
        rst = 1'b1;
        #1;
        armed_m = 1'b0;
        err_m   = 1'b0;
        for (int i = 0; i < N; i++) act_m[i] = '0;
        n_chk++;
        if (coeff_o !== '0 || busy_o !== 1'b0 || pending_o !== 1'b0 ||
            err_addr !== 1'b0 || swap_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_load: coeff=%h busy=%b pend=%b err=%b swap=%b want all 0",
                     coeff_o, busy_o, pending_o, err_addr, swap_done);
        end
        tick();
        rst = 1'b0;
        tick();
        do_commit();
        vs_swap(1'b0, 1'b0, "post_rst");
    endtask

    initial begin
        test_reset();
        test_first_swap();
        test_no_commit();
        test_commit_vs_same();
        test_bad_addr();
        test_back_to_back();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
